// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//
// Debounce filter and event generator for one mechanical contact (push-button
// or switch). Expects an already-synchronized input, so no synchronizer flops
// are added here.
//
// A level change on Sync_i is accepted only after DEBOUNCE_CYCLES consecutive
// identical samples. The accepted level is presented on State_o. One-cycle
// event pulses accompany it:
//   - Press_o marks the rising edge of State_o.
//   - Release_o marks the falling edge of State_o.
//   - LongPress_o fires once when State_o has been held high for
//     LONG_PRESS_CYCLES cycles.
//
// Parameters
//   DEBOUNCE_CYCLES   consecutive identical samples needed to accept a change (>=1)
//   LONG_PRESS_CYCLES cycles State_o must stay high before LongPress_o   (>=1)
//
// Ports
//   Clock        in   single clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   Sync_i       in   synchronized contact level, 1 = pressed
//   State_o      out  debounced level (registered)
//   Press_o      out  one-cycle pulse on State_o 0->1 (registered)
//   Release_o    out  one-cycle pulse on State_o 1->0 (registered)
//   LongPress_o  out  one-cycle pulse, at most once per press (registered)
//
// State table
//   state           | meaning
//   ----------------+-------------------------------------------------------
//   RELEASED        | accepted level 0, input agrees
//   CONFIRM_PRESS   | accepted level 0, counting consecutive 1 samples
//   PRESSED         | accepted level 1, input agrees
//   CONFIRM_RELEASE | accepted level 1, counting consecutive 0 samples
// -----------------------------------------------------------------------------
module debouncer #(
  parameter int DEBOUNCE_CYCLES   = 50_000,
  parameter int LONG_PRESS_CYCLES = 10_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Sync_i,
  output logic State_o,
  output logic Press_o,
  output logic Release_o,
  output logic LongPress_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  // The confirm counter enters a CONFIRM state already holding 1 (the first
  // sample). The sample seen while the count equals DEB_LAST is the one that
  // completes the run.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

  state_t          fsm_q,     fsm_d;
  logic [DW-1:0]   cnt_q,     cnt_d;
  logic [HW-1:0]   hold_q,    hold_d;
  logic            level_q,   level_d;
  logic            press_q,   press_d;
  logic            release_q, release_d;
  logic            long_q,    long_d;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      fsm_q     <= RELEASED;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: next state, confirm counter and level/edge pulses
  // ---------------------------------------------------------------------------
  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    unique case (fsm_q)
      RELEASED: begin
        if (Sync_i) begin
          // A single-sample filter accepts immediately, giving a pure
          // one-cycle delay of Sync_i.
          if (DEBOUNCE_CYCLES == 1) begin
            fsm_d   = PRESSED;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            fsm_d = CONFIRM_PRESS;
            cnt_d = DW'(1);
          end
        end
      end

      CONFIRM_PRESS: begin
        if (!Sync_i) begin
          fsm_d = RELEASED;
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          fsm_d   = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end

      PRESSED: begin
        if (!Sync_i) begin
          if (DEBOUNCE_CYCLES == 1) begin
            fsm_d     = RELEASED;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            fsm_d = CONFIRM_RELEASE;
            cnt_d = DW'(1);
          end
        end
      end

      CONFIRM_RELEASE: begin
        if (Sync_i) begin
          fsm_d = PRESSED;
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          fsm_d     = RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end

      default: begin
        fsm_d = RELEASED;
        cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Hold counter and long-press pulse
  // ---------------------------------------------------------------------------
  // The counter runs while the accepted level is 1. That includes
  // CONFIRM_RELEASE, because State_o is still high there. It saturates at
  // LONG_PRESS_CYCLES, so the pulse cannot fire again for the same press.
  //
  // A release confirmed on the same edge takes priority. The counter clears
  // and the long-press pulse is suppressed.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;

    if (press_d || release_d) begin
      hold_d = '0;
    end else if (level_q && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HW'(1);
      if (hold_q == HOLD_LAST) begin
        long_d = 1'b1;
      end
    end
  end

  assign State_o     = level_q;
  assign Press_o     = press_q;
  assign Release_o   = release_q;
  assign LongPress_o = long_q;

endmodule

// File: tb/tb_debouncer.sv
// -----------------------------------------------------------------------------
// tb_debouncer
//
// Directed bench for debouncer with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=20 on a 10 MHz clock.
//
// Outputs are viewed as obs = {State, Press, Release, LongPress}.
// Inputs change 1 ns after a rising edge and outputs are sampled at the same
// point, so each sample reflects the edge that just consumed the input.
// -----------------------------------------------------------------------------
module tb_debouncer;

  localparam int D = 4;
  localparam int L = 20;

  logic Clock = 1'b0;
  logic Reset;
  logic Sync_i;
  logic State_o;
  logic Press_o;
  logic Release_o;
  logic LongPress_o;
  logic [3:0] obs;

  int errors = 0;
  int checks = 0;

  debouncer #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Sync_i     (Sync_i),
    .State_o    (State_o),
    .Press_o    (Press_o),
    .Release_o  (Release_o),
    .LongPress_o(LongPress_o)
  );

  assign obs = {State_o, Press_o, Release_o, LongPress_o};

  always #50 Clock = ~Clock;

  // Apply one input sample and step to just after the edge that consumes it.
  task automatic tick(input logic s);
    Sync_i = s;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Sync_i = 1'b0;
    Reset  = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  // While Reset is held with Sync_i=1, all outputs stay 0. After release,
  // Press_o fires for exactly one cycle, after the 4th high sample.
  task automatic test_reset();
    logic [3:0] exp;
    Reset  = 1'b1;
    Sync_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge Clock);
      #1;
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs, 4'b0000);
      end
    end
    #20;
    Reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1);
      exp = (i < 4) ? 4'b0000 : (i == 4) ? 4'b1100 : 4'b1000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_release tick %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  // Sync_i high for 10 samples, then low.
  // Expect one press pulse, one release pulse and no long press.
  task automatic test_clean();
    logic [3:0] exp;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      tick(i <= 10);
      if (i < 4)        exp = 4'b0000;
      else if (i == 4)  exp = 4'b1100;
      else if (i <= 13) exp = 4'b1000;
      else if (i == 14) exp = 4'b0010;
      else              exp = 4'b0000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL clean tick %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  // Input pattern 1,1,1,0,1,1,0 then steady 1: no activity until 4 ones in a
  // row. A later 3-sample low glitch while pressed must be filtered out.
  task automatic test_bounce();
    logic [17:0] pat;
    logic [3:0]  exp;
    do_reset();
    // Ticks 1..18, MSB first: 1110110 1111 000 1111
    pat = 18'b1110110_1111_000_1111;
    for (int i = 1; i <= 18; i++) begin
      tick(pat[18 - i]);
      if (i < 11)       exp = 4'b0000;
      else if (i == 11) exp = 4'b1100;
      else              exp = 4'b1000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bounce tick %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  // Hold for 40 samples: one long press 20 cycles after the rise, then the
  // release. A second press repeats the long press at the same offset, which
  // shows the hold counter was cleared.
  task automatic test_long_press();
    logic [3:0] exp;
    do_reset();
    for (int i = 1; i <= 44; i++) begin
      tick(i <= 40);
      if (i < 4)        exp = 4'b0000;
      else if (i == 4)  exp = 4'b1100;
      else if (i == 24) exp = 4'b1001;
      else if (i <= 43) exp = 4'b1000;
      else              exp = 4'b0010;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long_press tick %0d: got %b expected %b", i, obs, exp);
      end
    end
    for (int i = 1; i <= 26; i++) begin
      tick(1'b1);
      if (i < 4)        exp = 4'b0000;
      else if (i == 4)  exp = 4'b1100;
      else if (i == 24) exp = 4'b1001;
      else              exp = 4'b1000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long_press_again tick %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  // Two release timings around the long-press edge.
  //
  // First run: release confirmation lands exactly on the hold count reaching
  // 20, so the release wins.
  //
  // Second run: the release lands one edge later. The long press then fires
  // during CONFIRM_RELEASE, followed by the release.
  task automatic test_collision();
    logic [3:0] exp;
    do_reset();
    for (int i = 1; i <= 26; i++) begin
      tick(i < 21);
      if (i < 4)        exp = 4'b0000;
      else if (i == 4)  exp = 4'b1100;
      else if (i <= 23) exp = 4'b1000;
      else if (i == 24) exp = 4'b0010;
      else              exp = 4'b0000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL collision tick %0d: got %b expected %b", i, obs, exp);
      end
    end
    do_reset();
    for (int i = 1; i <= 27; i++) begin
      tick(i < 22);
      if (i < 4)        exp = 4'b0000;
      else if (i == 4)  exp = 4'b1100;
      else if (i <= 23) exp = 4'b1000;
      else if (i == 24) exp = 4'b1001;
      else if (i == 25) exp = 4'b0010;
      else              exp = 4'b0000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL late_release tick %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  // Reset pulsed mid-press with the hold count at 10. Outputs must clear at
  // once. The held input is then re-detected after 4 samples, and the long
  // press follows 20 cycles later.
  task automatic test_reset_mid_press();
    logic [3:0] exp;
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      tick(1'b1);
    end
    checks++;
    if (obs !== 4'b1000) begin
      errors++;
      $display("FAIL mid_press_before got %b expected %b", obs, 4'b1000);
    end
    #20;
    Reset = 1'b1;
    #10;
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL mid_press_async_clear got %b expected %b", obs, 4'b0000);
    end
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      tick(1'b1);
      if (i < 4)        exp = 4'b0000;
      else if (i == 4)  exp = 4'b1100;
      else if (i == 24) exp = 4'b1001;
      else              exp = 4'b1000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_press_redetect tick %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    Reset  = 1'b1;
    Sync_i = 1'b0;
    test_reset();
    test_clean();
    test_bounce();
    test_long_press();
    test_collision();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
